at89_prog_sequencer: RTL and testbench
======================================

// Module: at89_prog_sequencer
// PURPOSE
//  Timed command executor for AT89C2051 programming: takes one-cycle commands from the host
//  bus register block and drives the DUT PROG (P3.2) and VPP/RST controls with exact pulse,
//  settle, ready-poll and erase timing. Sits downstream of the bus decode, upstream of the ZIF
//  pin drivers; samples DUT READY (P3.1) and reports busy/error for the status register.
// PARAMETERS
//  PULSE_CYCLES   24     PROG low time for a byte-program pulse (1 us @ 24 MHz)
//  SETTLE_CYCLES  2      wait after PROG rises before first READY sample
//  POLL_CYCLES    4800   wait between READY samples (200 us)
//  POLL_RETRIES   12     extra READY samples after the first before timeout
//  FINISH_CYCLES  24     hold time after READY before command completes
//  ERASE_CYCLES   24000  erase sub-interval (1 ms)
//  ERASE_REPEATS  10     number of erase sub-intervals
// PORTS
//  osc        in   1  24 MHz clock
//  rst        in   1  asynchronous reset, active high
//  cmd_valid  in   1  one-cycle command strobe
//  cmd        in   4  command code, valid with cmd_valid
//  ready_in   in   1  raw DUT READY (P3.1), asynchronous
//  busy       out  1  command executing
//  err        out  1  last program command timed out
//  overrun    out  1  a command was strobed while busy
//  dut_prog   out  1  PROG level to P3.2 driver
//  dut_vpp    out  1  VPP enable to RST/VPP driver
// BEHAVIOUR
//  Reset (async, any state): busy=0 err=0 overrun=0 dut_prog=0 dut_vpp=0, FSM->IDLE, counters 0.
//   Reset mid-command aborts it; no completion, outputs take reset values immediately.
//  ready_in passes a 2-flop synchroniser (ready_s); all READY decisions use ready_s.
//  Accept: cmd_valid=1 && busy=0 in cycle T -> command latched, busy=1 from T+1.
//   cmd_valid while busy=1: ignored, overrun=1 (sticky), cleared at next accepted command.
//  Commands (effects visible from T+1):
//   1 set PROG: dut_prog=1, busy=1 for one cycle, then 0.
//   2 clr PROG: dut_prog=0, one busy cycle.
//   5 set VPP / 6 clr VPP: dut_vpp=1/0, one busy cycle.
//   0,7-15: no-op, one busy cycle, no output change.
//   3 program byte: err=0 at T+1. FSM PULSE->SETTLE->POLL->FINISH->IDLE:
//    PULSE: dut_prog=0 for exactly PULSE_CYCLES cycles.
//    SETTLE: dut_prog=1, wait SETTLE_CYCLES cycles.
//    POLL: sample ready_s in first POLL cycle; 1 -> FINISH. 0 -> wait POLL_CYCLES, resample;
//     at most POLL_RETRIES+1 samples total; all 0 -> err=1, go FINISH.
//    FINISH: wait FINISH_CYCLES, then busy=0 (err holds until next cmd 3 or reset).
//   4 chip erase: dut_prog=0 for ERASE_CYCLES*ERASE_REPEATS cycles (repeat counter over
//    sub-interval counter, no gap between intervals), then dut_prog=1, busy=0 same cycle. err=0.
//  dut_vpp is never changed by commands 3/4; dut_prog unaffected by 5/6.
//  Counters sized from parameters; no wrap: every count terminates at 0 and FSM exits.
//  cmd accepted on the same cycle busy falls is legal only from the cycle after busy=0.
// TESTING
//  Reset then cmd 5, cmd 1 -> dut_vpp=1, dut_prog=1, each busy exactly 1 cycle, overrun=0.
//  cmd 3, ready_in=1 throughout -> dut_prog low 24 cycles, busy high 24+2+1+24 cycles, err=0.
//  cmd 3, ready_in=0 -> 13 samples 4800 cycles apart, err=1, busy falls 24 cycles after last.
//  cmd 4 -> dut_prog low exactly 240000 cycles, then dut_prog=1 and busy=0 together.
//  cmd_valid pulses during cmd 3 -> ignored, overrun=1; next accepted cmd clears overrun.
//  rst asserted mid-erase -> dut_prog=0, busy=0 immediately; cmd 1 afterwards works normally.

Source files
------------

// File: rtl/at89_prog_sequencer_if.sv
// Host-side command/status bundle between the bus register block and the
// AT89C2051 programming sequencer.
interface at89_prog_sequencer_if;
  logic       cmd_valid;
  logic [3:0] cmd;
  logic       busy;
  logic       err;
  logic       overrun;

  modport master (
    output cmd_valid,
    output cmd,
    input  busy,
    input  err,
    input  overrun
  );

  modport slave (
    input  cmd_valid,
    input  cmd,
    output busy,
    output err,
    output overrun
  );
endinterface

// File: rtl/at89_prog_sequencer.sv
// Timed command executor for AT89C2051 programming: drives PROG and VPP with
// pulse, settle, READY-poll and erase timing, and reports busy/err/overrun.
module at89_prog_sequencer #(
  parameter int PULSE_CYCLES  = 24,
  parameter int SETTLE_CYCLES = 2,
  parameter int POLL_CYCLES   = 4800,
  parameter int POLL_RETRIES  = 12,
  parameter int FINISH_CYCLES = 24,
  parameter int ERASE_CYCLES  = 24000,
  parameter int ERASE_REPEATS = 10
) (
  input  logic                  osc,
  input  logic                  rst,
  at89_prog_sequencer_if.slave  host,
  input  logic                  ready_in,
  output logic                  dut_prog,
  output logic                  dut_vpp
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max2(max2(max2(PULSE_CYCLES, SETTLE_CYCLES),
                                     max2(POLL_CYCLES, FINISH_CYCLES)),
                                ERASE_CYCLES);
  localparam int CW = max2(1, $clog2(CNT_MAX + 1));
  localparam int RW = max2(1, $clog2(ERASE_REPEATS + 1));
  localparam int TW = max2(1, $clog2(POLL_RETRIES + 1));

  // Each timed state is loaded with (duration - 1) and leaves when it reaches 0.
  localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] POLL_LD   = CW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] FINISH_LD = CW'(FINISH_CYCLES - 1);
  localparam logic [CW-1:0] ERASE_LD  = CW'(ERASE_CYCLES - 1);
  localparam logic [RW-1:0] REP_LD    = RW'(ERASE_REPEATS - 1);
  localparam logic [TW-1:0] RETRY_LD  = TW'(POLL_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_ONE, S_PULSE, S_SETTLE, S_POLL, S_FINISH, S_ERASE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RW-1:0] rep, rep_n;
  logic [TW-1:0] retry, retry_n;
  logic          prog_q, prog_n;
  logic          vpp_q, vpp_n;
  logic          err_q, err_n;
  logic          ovr_q, ovr_n;
  logic          ready_meta, ready_s;
  logic          accept;

  assign accept = host.cmd_valid && (state == S_IDLE);

  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rep        <= '0;
      retry      <= '0;
      prog_q     <= 1'b0;
      vpp_q      <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      ready_meta <= 1'b0;
      ready_s    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rep        <= rep_n;
      retry      <= retry_n;
      prog_q     <= prog_n;
      vpp_q      <= vpp_n;
      err_q      <= err_n;
      ovr_q      <= ovr_n;
      ready_meta <= ready_in;
      ready_s    <= ready_meta;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rep_n   = rep;
    retry_n = retry;
    case (state)
      S_IDLE: begin
        if (host.cmd_valid) begin
          case (host.cmd)
            4'd3: begin
              state_n = S_PULSE;
              cnt_n   = PULSE_LD;
            end
            4'd4: begin
              state_n = S_ERASE;
              cnt_n   = ERASE_LD;
              rep_n   = REP_LD;
            end
            default: state_n = S_ONE;
          endcase
        end
      end
      S_ONE: state_n = S_IDLE;
      S_PULSE: begin
        if (cnt == '0) begin
          state_n = S_SETTLE;
          cnt_n   = SETTLE_LD;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt == '0) begin
          state_n = S_POLL;
          cnt_n   = '0;
          retry_n = RETRY_LD;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      // READY is only sampled when the poll interval counter is at 0.
      S_POLL: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else if (ready_s || (retry == '0)) begin
          state_n = S_FINISH;
          cnt_n   = FINISH_LD;
        end else begin
          retry_n = retry - TW'(1);
          cnt_n   = POLL_LD;
        end
      end
      S_FINISH: begin
        if (cnt == '0) state_n = S_IDLE;
        else           cnt_n   = cnt - CW'(1);
      end
      S_ERASE: begin
        if (cnt == '0) begin
          if (rep == '0) begin
            state_n = S_IDLE;
          end else begin
            rep_n = rep - RW'(1);
            cnt_n = ERASE_LD;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    prog_n = prog_q;
    vpp_n  = vpp_q;
    err_n  = err_q;
    ovr_n  = ovr_q;
    if (host.cmd_valid) ovr_n = !accept;
    case (state)
      S_IDLE: begin
        if (host.cmd_valid) begin
          case (host.cmd)
            4'd1: prog_n = 1'b1;
            4'd2: prog_n = 1'b0;
            4'd3: begin
              prog_n = 1'b0;
              err_n  = 1'b0;
            end
            4'd4: begin
              prog_n = 1'b0;
              err_n  = 1'b0;
            end
            4'd5: vpp_n = 1'b1;
            4'd6: vpp_n = 1'b0;
            default: ;
          endcase
        end
      end
      S_PULSE: if (cnt == '0) prog_n = 1'b1;
      S_POLL:  if ((cnt == '0) && !ready_s && (retry == '0)) err_n = 1'b1;
      // PROG rises on the same edge that returns the FSM to idle.
      S_ERASE: if ((cnt == '0) && (rep == '0)) prog_n = 1'b1;
      default: ;
    endcase
  end

  assign host.busy    = (state != S_IDLE);
  assign host.err     = err_q;
  assign host.overrun = ovr_q;
  assign dut_prog     = prog_q;
  assign dut_vpp      = vpp_q;

endmodule

// File: tb/tb_at89_prog_sequencer.sv
// Randomised command stream against a timing model of the AT89 programming
// sequencer, with directed reset, program, timeout and erase cases.
module tb_at89_prog_sequencer;

  localparam int P  = 5;
  localparam int S  = 2;
  localparam int PL = 20;
  localparam int R  = 3;
  localparam int F  = 4;
  localparam int E  = 15;
  localparam int ER = 3;

  logic osc = 1'b0;
  logic rst;
  logic ready_in;
  logic dut_prog;
  logic dut_vpp;

  at89_prog_sequencer_if bus ();

  at89_prog_sequencer #(
    .PULSE_CYCLES (P),
    .SETTLE_CYCLES(S),
    .POLL_CYCLES  (PL),
    .POLL_RETRIES (R),
    .FINISH_CYCLES(F),
    .ERASE_CYCLES (E),
    .ERASE_REPEATS(ER)
  ) u_dut (
    .osc     (osc),
    .rst     (rst),
    .host    (bus),
    .ready_in(ready_in),
    .dut_prog(dut_prog),
    .dut_vpp (dut_vpp)
  );

  always #5 osc = ~osc;

  int   checks = 0;
  int   passed = 0;
  logic exp_prog, exp_vpp, exp_err, exp_ovr;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    exp_prog = 1'b0;
    exp_vpp  = 1'b0;
    exp_err  = 1'b0;
    exp_ovr  = 1'b0;
  endtask

  // ready_sample: index of the first READY sample that sees 1 (-1 = never).
  // inj: relative cycle at which a stray strobe is sent while busy (0 = none).
  task automatic apply_stimulus(input logic [3:0] c, input int ready_sample, input int inj);
    int k = 0;
    int busy_cnt = 0;
    int plow = 0;
    int rise = -1;
    int exp_busy;
    int exp_plow;
    int first_sample;
    int last_sample;
    bit hit;

    case (c)
      4'd3: begin
        first_sample = P + S + 1;
        hit          = (ready_sample >= 0) && (ready_sample <= R);
        last_sample  = first_sample + (hit ? ready_sample : R) * PL;
        exp_busy     = last_sample + F;
        exp_plow     = P;
        exp_prog     = 1'b1;
        exp_err      = !hit;
        if (hit) rise = first_sample + ready_sample * PL - 5;
      end
      4'd4: begin
        exp_busy = E * ER;
        exp_plow = E * ER;
        exp_prog = 1'b1;
        exp_err  = 1'b0;
      end
      default: begin
        exp_busy = 1;
        if (c == 4'd1) exp_prog = 1'b1;
        if (c == 4'd2) exp_prog = 1'b0;
        if (c == 4'd5) exp_vpp  = 1'b1;
        if (c == 4'd6) exp_vpp  = 1'b0;
        exp_plow = exp_prog ? 0 : 1;
      end
    endcase
    exp_ovr = (inj > 0);

    if (c == 4'd3) ready_in = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    while (k < 2000) begin
      @(negedge osc);
      k++;
      bus.cmd_valid = (k == inj);
      if (k == rise) ready_in = 1'b1;
      if ((c == 4'd3) && (k == 1)) check_output("err_cleared_at_start", bus.err, 0);
      if (!bus.busy) break;
      busy_cnt++;
      if (dut_prog === 1'b0) plow++;
    end
    bus.cmd_valid = 1'b0;

    check_output($sformatf("cmd%0d_busy_cycles", c), busy_cnt, exp_busy);
    check_output($sformatf("cmd%0d_prog_low_cycles", c), plow, exp_plow);
    check_output($sformatf("cmd%0d_dut_prog", c), dut_prog, exp_prog);
    check_output($sformatf("cmd%0d_dut_vpp", c), dut_vpp, exp_vpp);
    check_output($sformatf("cmd%0d_err", c), bus.err, exp_err);
    check_output($sformatf("cmd%0d_overrun", c), bus.overrun, exp_ovr);
  endtask

  initial begin
    logic [3:0] c;
    int         rs;
    int         inj;

    rst           = 1'b1;
    ready_in      = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 4'd0;
    model_reset();
    repeat (3) @(negedge osc);
    check_output("reset_busy", bus.busy, 0);
    check_output("reset_err", bus.err, 0);
    check_output("reset_overrun", bus.overrun, 0);
    check_output("reset_prog", dut_prog, 0);
    check_output("reset_vpp", dut_vpp, 0);
    rst = 1'b0;
    @(negedge osc);

    apply_stimulus(4'd5, -1, 0);
    apply_stimulus(4'd1, -1, 0);
    apply_stimulus(4'd3, 0, 0);
    apply_stimulus(4'd3, -1, 3);
    apply_stimulus(4'd2, -1, 0);
    apply_stimulus(4'd4, -1, 7);
    apply_stimulus(4'd6, -1, 0);
    apply_stimulus(4'd9, -1, 0);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: c = 4'd3;
        3:       c = 4'd4;
        default: c = 4'($urandom_range(0, 15));
      endcase
      rs = $urandom_range(0, R + 1);
      if (rs == R + 1) rs = -1;
      inj = 0;
      if (((c == 4'd3) || (c == 4'd4)) && ($urandom_range(0, 1) == 1))
        inj = $urandom_range(2, P);
      apply_stimulus(c, rs, inj);
      repeat ($urandom_range(0, 2)) @(negedge osc);
    end

    // Abort an erase part-way through and confirm a clean restart.
    apply_stimulus(4'd5, -1, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd       = 4'd4;
    @(negedge osc);
    bus.cmd_valid = 1'b0;
    repeat (20) @(negedge osc);
    check_output("erase_midway_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    model_reset();
    check_output("abort_busy", bus.busy, 0);
    check_output("abort_prog", dut_prog, 0);
    check_output("abort_vpp", dut_vpp, 0);
    @(negedge osc);
    rst = 1'b0;
    @(negedge osc);
    apply_stimulus(4'd1, -1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
